// File: rtl/vga_timing_pkg.sv
// Shared types and defaults for the VGA timing generator (640x480@60 defaults).
// Optional pixel-enable build: define VGA_TIMING_CE_EN.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 12;

  function automatic int axis_total(input int active_len, input int fp_len,
                                    input int sync_len, input int bp_len);
    return active_len + fp_len + sync_len + bp_len;
  endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK sequencer.
module vga_timing_axis
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = 1'b0,
  parameter int   CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [CNT_W-1:0] pos,
  output logic             sync,
  output logic             active,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] POS_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_ACT  = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FP   = CNT_W'(FP - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(SYNC - 1);
  localparam logic [CNT_W-1:0] LAST_BP   = CNT_W'(BP - 1);
  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 || TOTAL > (2 ** CNT_W)) begin : g_cfg_err
    $error("vga_timing_axis: every segment must be >= 1 and the total must fit in CNT_W bits");
  end

  axis_state_e      state_r;
  logic [CNT_W-1:0] seg_r;
  logic [CNT_W-1:0] pos_r;
  logic [CNT_W-1:0] seg_last_s;

  // Last in-segment count of the current state.
  always_comb begin
    seg_last_s = LAST_ACT;
    case (state_r)
      ST_ACTIVE: seg_last_s = LAST_ACT;
      ST_FRONT:  seg_last_s = LAST_FP;
      ST_SYNC:   seg_last_s = LAST_SYNC;
      ST_BACK:   seg_last_s = LAST_BP;
      default:   seg_last_s = LAST_ACT;
    endcase
  end

  // Position counter and segment sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ACTIVE;
      seg_r   <= ZERO;
      pos_r   <= ZERO;
    end else if (advance) begin
      pos_r <= (pos_r == POS_LAST) ? ZERO : pos_r + ONE;
      if (seg_r == seg_last_s) begin
        seg_r <= ZERO;
        case (state_r)
          ST_ACTIVE: state_r <= ST_FRONT;
          ST_FRONT:  state_r <= ST_SYNC;
          ST_SYNC:   state_r <= ST_BACK;
          ST_BACK:   state_r <= ST_ACTIVE;
          default:   state_r <= ST_ACTIVE;
        endcase
      end else begin
        seg_r <= seg_r + ONE;
      end
    end
  end

  assign pos    = pos_r;
  assign sync   = (state_r == ST_SYNC) ? POL : ~POL;
  assign active = (state_r == ST_ACTIVE);
  assign wrap   = (pos_r == POS_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: registered syncs, display enable, coordinates and strobes.
// Define VGA_TIMING_CE_EN to add the pix_ce pixel-advance enable port.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
`ifdef VGA_TIMING_CE_EN
  input  logic             pix_ce,
`endif
  output logic             h_sync,
  output logic             v_sync,
  output logic             disp_en,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             line_start,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};

  logic             ce_s;
  logic             v_adv_s;
  logic [CNT_W-1:0] h_pos_s;
  logic [CNT_W-1:0] v_pos_s;
  logic             h_sync_s;
  logic             v_sync_s;
  logic             h_act_s;
  logic             v_act_s;
  logic             h_wrap_s;
  logic             v_wrap_unused_s;

`ifdef VGA_TIMING_CE_EN
  assign ce_s = pix_ce;
`else
  assign ce_s = 1'b1;
`endif

  // Row steps only on the pixel that closes a line.
  assign v_adv_s = h_wrap_s & ce_s;

  vga_timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(H_SYNC_POL), .CNT_W(CNT_W)
  ) u_h_axis (
    .clk(clk), .rst(rst), .advance(ce_s),
    .pos(h_pos_s), .sync(h_sync_s), .active(h_act_s), .wrap(h_wrap_s)
  );

  vga_timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(V_SYNC_POL), .CNT_W(CNT_W)
  ) u_v_axis (
    .clk(clk), .rst(rst), .advance(v_adv_s),
    .pos(v_pos_s), .sync(v_sync_s), .active(v_act_s), .wrap(v_wrap_unused_s)
  );

  // Output stage: one cycle behind the counters so every output stays aligned with col/row.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_sync      <= ~H_SYNC_POL;
      v_sync      <= ~V_SYNC_POL;
      disp_en     <= 1'b0;
      col         <= ZERO;
      row         <= ZERO;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce_s) begin
      h_sync      <= h_sync_s;
      v_sync      <= v_sync_s;
      disp_en     <= h_act_s & v_act_s;
      col         <= h_pos_s;
      row         <= v_pos_s;
      line_start  <= (h_pos_s == ZERO);
      frame_start <= (h_pos_s == ZERO) && (v_pos_s == ZERO);
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator and successor to the fixed-total sync pulse generator. Each axis has explicit front-porch, sync and back-porch lengths, and each sync has a programmable polarity. Outputs are registered h_sync/v_sync, display enable, aligned pixel coordinates and line/frame start strobes. Sits between the pixel clock domain and the pong renderer, which draws from col/row/disp_en.

Parameters:
H_ACTIVE, 640, visible columns
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible rows
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
H_SYNC_POL, 0, asserted level of h_sync (0 = active-low)
V_SYNC_POL, 0, asserted level of v_sync
CNT_W, 12, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
pix_ce  in  1  pixel advance enable (present only with VGA_TIMING_CE_EN)
h_sync  out  1  horizontal sync, polarity per H_SYNC_POL
v_sync  out  1  vertical sync, polarity per V_SYNC_POL
disp_en  out  1  high when col<H_ACTIVE and row<V_ACTIVE
col  out  CNT_W  column of current output cycle
row  out  CNT_W  row of current output cycle
line_start  out  1  one-cycle pulse at col==0
frame_start  out  1  one-cycle pulse at col==0 and row==0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL likewise (default 525).
- Per-axis state machine: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Each state is held for its parameter length.
  - The per-state position count is unsigned CNT_W.
  - The axis position counter wraps at TOTAL-1 to 0.
- Horizontal axis advances every enabled cycle.
- Vertical axis advances only on the cycle the horizontal counter wraps (H_TOTAL-1 -> 0).
  - At the simultaneous wrap (col H_TOTAL-1, row V_TOTAL-1), both axes go to 0 in the same cycle.
- h_sync is asserted for col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. v_sync is asserted similarly on rows.
- All outputs are registered and reflect the counter state of the previous cycle (latency 1). col/row are delayed identically, so all outputs stay mutually aligned.
- Reset (rst high at a clk edge, any point in a frame):
  - counters go to 0 and both FSMs to ACTIVE;
  - outputs go to h_sync=~H_SYNC_POL, v_sync=~V_SYNC_POL, disp_en=0, col=0, row=0, line_start=0, frame_start=0.
- First edge after rst deasserts: outputs show col=0, row=0, disp_en=1, line_start=1, frame_start=1.
- Zero-length porches are not supported; each of H_FP, H_SYNC, H_BP, V_FP, V_SYNC, V_BP must be >=1. Elaboration-time check: error if any is 0 or a total exceeds 2^CNT_W.

Optional Feature:
Macro VGA_TIMING_CE_EN.
- Defined: pix_ce port exists. Counters, FSMs and output registers update only on cycles where pix_ce=1; otherwise every output holds. Strobes last exactly one enabled cycle, not one clk. rst overrides pix_ce. This allows running from a 2x/4x system clock.
- Undefined: no pix_ce port; behaves as if pix_ce=1 permanently.

Decomposition:
- Package vga_timing_pkg holds:
  - the axis state enum (ACTIVE, FRONT, SYNC, BACK);
  - default 640x480@60 constants;
  - a helper function computing TOTAL from the four lengths.
- Sub-module vga_timing_axis: one position counter plus FSM with parameters ACTIVE/FP/SYNC/BP/POL. Inputs advance and rst; outputs pos, sync, active, wrap. Instantiated twice: horizontal advance = pix_ce, vertical advance = horizontal wrap & pix_ce.

Test Plan:
- Reset with defaults: all outputs at reset values while rst=1; first cycle after release gives col=0, row=0, disp_en=1, frame_start=1.
- Defaults, active-low: h_sync low for exactly 96 cycles, spanning output col 656..751; period is 800 clocks; v_sync low during rows 490..491 only.
- Frame length: frame_start pulses are spaced exactly 420000 clocks apart; line_start pulses 800 apart; disp_en high for 307200 cycles per frame.
- Tiny config (H 4/1/1/2, V 3/1/1/1, both POL=1): cycle-exact compare against a reference model over 3 frames, including the simultaneous row/col wrap at (7,5) -> (0,0).
- Reset mid-frame at col 300, row 200: next output col=0, row=0 with syncs inactive; the following frame_start arrives exactly 420000 clocks after release.
- With VGA_TIMING_CE_EN and pix_ce every 4th cycle: outputs update only on enabled cycles; h_sync spans 384 clk; frame_start lasts 4 clk; pix_ce=0 during rst still resets.
